// File: rtl/gray_updown_counter.sv
// Prescaled up/down binary counter with a registered gray-coded mirror.
// Optional GRAY_CNT_LOAD_EN macro adds the load / load_gray ports and load logic.
module gray_updown_counter #(
  parameter int BITS     = 8,
  parameter int PRESCALE = 16,
  parameter int SATURATE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            dir,
  input  logic            clr,
`ifdef GRAY_CNT_LOAD_EN
  input  logic            load,
  input  logic [BITS-1:0] load_gray,
`endif
  output logic [BITS-1:0] value,
  output logic [BITS-1:0] binary,
  output logic            tick,
  output logic            wrap
);

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]   ps, ps_nxt;
  logic [BITS-1:0] bin_nxt;
  logic            tick_nxt, wrap_nxt;
  logic            step, at_max, at_min;

  assign step   = en && (ps == PS_LAST);
  assign at_max = &binary;
  assign at_min = ~|binary;

`ifdef GRAY_CNT_LOAD_EN
  // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
  logic [BITS-1:0] load_bin;
  for (genvar i = 0; i < BITS; i++) begin : g_g2b
    assign load_bin[i] = ^load_gray[BITS-1:i];
  end
`endif

  always_comb begin
    ps_nxt   = ps;
    bin_nxt  = binary;
    tick_nxt = 1'b0;
    wrap_nxt = 1'b0;
    if (clr) begin
      ps_nxt  = '0;
      bin_nxt = '0;
    end
`ifdef GRAY_CNT_LOAD_EN
    else if (load) begin
      ps_nxt  = '0;
      bin_nxt = load_bin;
    end
`endif
    else if (step) begin
      ps_nxt   = '0;
      tick_nxt = 1'b1;
      if (dir) begin
        if (at_max) begin
          wrap_nxt = 1'b1;
          bin_nxt  = (SATURATE != 0) ? binary : '0;
        end else begin
          bin_nxt = binary + 1'b1;
        end
      end else begin
        if (at_min) begin
          wrap_nxt = 1'b1;
          bin_nxt  = (SATURATE != 0) ? binary : '1;
        end else begin
          bin_nxt = binary - 1'b1;
        end
      end
    end else if (en) begin
      ps_nxt = ps + 1'b1;
    end
  end

  // value is derived from the next-state binary so both registers change together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps     <= '0;
      binary <= '0;
      value  <= '0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      ps     <= ps_nxt;
      binary <= bin_nxt;
      value  <= bin_nxt ^ (bin_nxt >> 1);
      tick   <= tick_nxt;
      wrap   <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_gray_updown_counter.sv
// Randomised and directed checks of gray_updown_counter (wrap and saturate
// instances) against an arithmetic reference model.
module tb_gray_updown_counter;
  localparam int BITS = 4;
  localparam int PRE  = 3;
  localparam int MAXV = (1 << BITS) - 1;

  logic clk = 1'b0;
  logic rst, en, dir, clr, load;
  logic [BITS-1:0] load_gray;
  logic [BITS-1:0] v0, b0, v1, b1;
  logic t0, w0, t1, w1;

  int mc[2], mp[2];
  bit mt[2], mw[2];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  gray_updown_counter #(.BITS(BITS), .PRESCALE(PRE), .SATURATE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr),
`ifdef GRAY_CNT_LOAD_EN
    .load(load), .load_gray(load_gray),
`endif
    .value(v0), .binary(b0), .tick(t0), .wrap(w0));

  gray_updown_counter #(.BITS(BITS), .PRESCALE(PRE), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr),
`ifdef GRAY_CNT_LOAD_EN
    .load(load), .load_gray(load_gray),
`endif
    .value(v1), .binary(b1), .tick(t1), .wrap(w1));

  function automatic logic [BITS-1:0] gray(input int n);
    return BITS'(n ^ (n >> 1));
  endfunction

  function automatic int g2b(input int g);
    int b = g;
    for (int sh = 1; sh < BITS; sh++) b = b ^ (g >> sh);
    return b & MAXV;
  endfunction

  task automatic model(input int s);
    mt[s] = 0; mw[s] = 0;
    if (clr) begin
      mc[s] = 0; mp[s] = 0;
    end else if (load) begin
      mc[s] = g2b(int'(load_gray)); mp[s] = 0;
    end else if (en) begin
      if (mp[s] == PRE - 1) begin
        mp[s] = 0; mt[s] = 1;
        if (dir) begin
          if (mc[s] == MAXV) begin mw[s] = 1; if (s == 0) mc[s] = 0; end
          else mc[s] = mc[s] + 1;
        end else begin
          if (mc[s] == 0) begin mw[s] = 1; if (s == 0) mc[s] = MAXV; end
          else mc[s] = mc[s] - 1;
        end
      end else mp[s] = mp[s] + 1;
    end
  endtask

  task automatic mreset();
    for (int s = 0; s < 2; s++) begin mc[s] = 0; mp[s] = 0; mt[s] = 0; mw[s] = 0; end
  endtask

  // One clock: predict, then sample 1 time unit after the rising edge.
  task automatic advance();
`ifndef GRAY_CNT_LOAD_EN
    load = 1'b0;
`endif
    model(0); model(1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    en = 0; dir = 1; clr = 0; load = 0; load_gray = '0;
    rst = 1; #3; rst = 0;
    mreset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    en = 0; dir = 1; clr = 0; load = 0; load_gray = '0;
    rst = 1; #12;
    checks++;
    if ({v0, b0, t0, w0} !== '0) begin errors++; $display("FAIL reset_dut0 got %h want 0", {v0, b0, t0, w0}); end
    checks++;
    if ({v1, b1, t1, w1} !== '0) begin errors++; $display("FAIL reset_dut1 got %h want 0", {v1, b1, t1, w1}); end
    rst = 0; mreset();
    @(posedge clk); #1;
  endtask

  task automatic test_up_sequence();
    logic [BITS-1:0] exp_seq [16];
    logic [BITS-1:0] prev;
    int k = 0;
    exp_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    do_reset();
    en = 1; dir = 1; prev = v0;
    for (int i = 1; i <= 60 && k < 16; i++) begin
      advance();
      checks++;
      if (t0 !== (i % PRE == 0)) begin errors++; $display("FAIL up_tick_spacing cycle %0d got %b", i, t0); end
      checks++;
      if ({v0, b0, t0, w0} !== {gray(mc[0]), BITS'(mc[0]), mt[0], mw[0]})
        begin errors++; $display("FAIL up_model got %h want %h", {v0, b0, t0, w0}, {gray(mc[0]), BITS'(mc[0]), mt[0], mw[0]}); end
      if (t0) begin
        checks++;
        if (v0 !== exp_seq[k]) begin errors++; $display("FAIL up_seq idx %0d got %h want %h", k, v0, exp_seq[k]); end
        checks++;
        if (w0 !== (k == 15)) begin errors++; $display("FAIL up_wrap idx %0d got %b want %b", k, w0, k == 15); end
        checks++;
        if ($countones(v0 ^ prev) != 1) begin errors++; $display("FAIL up_one_bit got %h prev %h", v0, prev); end
        prev = v0; k++;
      end
    end
    checks++;
    if (k != 16) begin errors++; $display("FAIL up_tick_count got %0d want 16", k); end
  endtask

  task automatic test_down();
    do_reset();
    en = 1; dir = 0;
    repeat (PRE) advance();
    checks++;
    if ({b0, v0, t0, w0} !== {4'hF, 4'h8, 1'b1, 1'b1}) begin errors++; $display("FAIL down_first got %h want f811", {b0, v0, t0, w0}); end
    repeat (PRE) advance();
    checks++;
    if ({b0, v0, t0, w0} !== {4'hE, 4'h9, 1'b1, 1'b0}) begin errors++; $display("FAIL down_second got %h want e910", {b0, v0, t0, w0}); end
  endtask

  task automatic test_saturate();
    int held = 0, prev, n;
    do_reset();
    en = 1; dir = 1;
    for (n = 0; n < 100 && held < 3; n++) begin
      prev = mc[1];
      advance();
      checks++;
      if ({v1, b1, t1, w1} !== {gray(mc[1]), BITS'(mc[1]), mt[1], mw[1]})
        begin errors++; $display("FAIL sat_model got %h want %h", {v1, b1, t1, w1}, {gray(mc[1]), BITS'(mc[1]), mt[1], mw[1]}); end
      if (mt[1] && prev == MAXV) begin
        checks++;
        if ({b1, v1, t1, w1} !== {4'hF, 4'h8, 1'b1, 1'b1}) begin errors++; $display("FAIL sat_hold got %h want f811", {b1, v1, t1, w1}); end
        held++;
      end
    end
    checks++;
    if (held < 3) begin errors++; $display("FAIL sat_timeout held %0d want 3", held); end
    dir = 0;
    for (n = 0; n < 10 && !t1; n++) advance();
    if (!t1) advance();
    for (n = 0; n < 10; n++) begin advance(); if (t1) break; end
    checks++;
    if ({b1, t1, w1} !== {4'hE, 1'b1, 1'b0}) begin errors++; $display("FAIL sat_reverse got %h want e2", {b1, t1, w1}); end
  endtask

  task automatic test_en_pause();
    do_reset();
    en = 1; dir = 1;
    advance();
    en = 0;
    for (int i = 0; i < 5; i++) begin
      advance();
      checks++;
      if (t0 !== 1'b0) begin errors++; $display("FAIL pause_no_tick cycle %0d got %b want 0", i, t0); end
    end
    en = 1;
    advance();
    checks++;
    if (t0 !== 1'b0) begin errors++; $display("FAIL pause_early_tick got %b want 0", t0); end
    advance();
    checks++;
    if ({t0, b0} !== {1'b1, 4'h1}) begin errors++; $display("FAIL pause_resume got %h want 11", {t0, b0}); end
  endtask

  task automatic test_clr_load();
    int n;
    do_reset();
    en = 1; dir = 1;
    for (n = 0; n < 60 && !(mc[0] == 7 && mp[0] == PRE - 1); n++) advance();
    checks++;
    if (b0 !== 4'h7) begin errors++; $display("FAIL clr_setup got %h want 7", b0); end
    clr = 1; advance(); clr = 0;
    checks++;
    if ({b0, v0, t0, w0} !== '0) begin errors++; $display("FAIL clr_over_step got %h want 0", {b0, v0, t0, w0}); end
`ifdef GRAY_CNT_LOAD_EN
    load = 1; load_gray = 4'hC; advance(); load = 0;
    checks++;
    if ({b0, v0, t0, w0} !== {4'h8, 4'hC, 1'b0, 1'b0}) begin errors++; $display("FAIL load got %h want 8c00", {b0, v0, t0, w0}); end
    for (n = 0; n < 10; n++) begin advance(); if (t0) break; end
    checks++;
    if ({b0, v0, t0} !== {4'h9, 4'hD, 1'b1}) begin errors++; $display("FAIL load_next got %h want 9d1", {b0, v0, t0}); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      dir = $urandom_range(0, 1) == 1;
      clr = ($urandom_range(0, 31) == 0);
`ifdef GRAY_CNT_LOAD_EN
      load = ($urandom_range(0, 15) == 0);
      load_gray = BITS'($urandom);
`endif
      advance();
      checks++;
      if ({v0, b0, t0, w0} !== {gray(mc[0]), BITS'(mc[0]), mt[0], mw[0]})
        begin errors++; $display("FAIL rand_wrap cycle %0d got %h want %h", i, {v0, b0, t0, w0}, {gray(mc[0]), BITS'(mc[0]), mt[0], mw[0]}); end
      checks++;
      if ({v1, b1, t1, w1} !== {gray(mc[1]), BITS'(mc[1]), mt[1], mw[1]})
        begin errors++; $display("FAIL rand_sat cycle %0d got %h want %h", i, {v1, b1, t1, w1}, {gray(mc[1]), BITS'(mc[1]), mt[1], mw[1]}); end
    end
    clr = 0; load = 0;
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    en = 1; dir = 1;
    for (n = 0; n < 60 && mc[0] != 10; n++) advance();
    checks++;
    if (b0 !== 4'hA) begin errors++; $display("FAIL areset_setup got %h want a", b0); end
    en = 0;
    #2 rst = 1;
    #1;
    checks++;
    if ({v0, b0, t0, w0} !== '0) begin errors++; $display("FAIL areset_immediate got %h want 0", {v0, b0, t0, w0}); end
    #1 rst = 0;
    mreset();
    @(posedge clk); #1;
    en = 1;
    for (int i = 1; i <= PRE; i++) begin
      advance();
      checks++;
      if (t0 !== (i == PRE)) begin errors++; $display("FAIL areset_first_tick cycle %0d got %b", i, t0); end
    end
  endtask

  initial begin
    test_reset();
    test_up_sequence();
    test_down();
    test_saturate();
    test_en_pause();
    test_clr_load();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/gray_updown_counter.md
Name: gray_updown_counter

Overview:
Parametrised successor to the fixed up-only gray counter. It has an internal prescaler, an up/down binary core and registered gray-coded output. It adds direction control, synchronous clear, wrap or saturate mode, and step/wrap strobes. The gray output is safe for consumers in other clock domains. It sits between the system clock and any block needing a slow, single-bit-change position or timestamp.

Parameters:
BITS, 8, counter width in bits (>=2)
PRESCALE, 16, system clocks per count step while enabled (>=1); prescaler width is $clog2(PRESCALE), minimum 1 bit
SATURATE, 0, 0 = wrap at the ends of the range; 1 = hold at all-ones (counting up) or zero (counting down)

Ports:
clk  input  1  system clock; all state is rising-edge
rst  input  1  asynchronous reset, active-high
en  input  1  prescaler and count enable
dir  input  1  1 = count up, 0 = count down; sampled on step cycles
clr  input  1  synchronous clear of counter and prescaler
load  input  1  synchronous load (only with GRAY_CNT_LOAD_EN)
load_gray  input  BITS  gray value to load (only with GRAY_CNT_LOAD_EN)
value  output  BITS  registered gray code of the count
binary  output  BITS  registered binary count
tick  output  1  one-cycle pulse, high in the first cycle a new stepped value is visible
wrap  output  1  one-cycle pulse coincident with a wrap (SATURATE=0) or a blocked step at a limit (SATURATE=1)

Behaviour:
- Reset (async assert, sync release by the system): prescaler=0, binary=0, value=0, tick=0, wrap=0.
- Internal step = en && (prescaler == PRESCALE-1).
- Prescaler: increments when en=1 and resets to 0 on step; holds when en=0. PRESCALE=1 makes every enabled cycle a step.
- Priority per edge, highest first: clr, load, step, hold.
- clr: binary=0, value=0, prescaler=0; tick and wrap low in the following cycle.
- step up:
  - SATURATE=0: binary+1 mod 2^BITS; the transition from all-ones to 0 sets wrap.
  - SATURATE=1: at all-ones, binary holds and wrap is set.
- step down:
  - SATURATE=0: binary-1 mod 2^BITS; the transition from 0 to all-ones sets wrap.
  - SATURATE=1: at 0, binary holds and wrap is set.
- value is registered from next-state binary as (b ^ (b>>1)). value and binary therefore always change on the same edge, and value never shows an intermediate code. Consecutive steps change exactly one bit of value. A held saturated step changes no bits.
- Latency: step in cycle N gives new value/binary, tick=1 and any wrap pulse in cycle N+1. tick is high for every step, including a saturated hold.
- en deasserted mid-prescale: the prescaler freezes, and the count resumes from the same phase when en returns.
- dir changing between steps is legal. The new direction takes effect on the next step. Changes of dir on non-step cycles have no effect.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

Optional Feature:
GRAY_CNT_LOAD_EN
- Defined: the load and load_gray ports exist. On load (without clr): value=load_gray, binary=gray-to-binary(load_gray) via a prefix XOR from the MSB, prescaler=0. The edge produces tick=0 and wrap=0. Load overrides a coincident step. The next step counts from the loaded value.
- Undefined: the ports are absent and there is no load logic. All other behaviour is identical.

Test Plan:
BITS=4, PRESCALE=3, SATURATE=0, en=1, dir=1 held after reset -> tick every 3rd cycle; value sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; wrap pulses with the 8->0 step; exactly one bit of value changes per tick.
Same config, dir=0 from reset -> first step gives binary=F, value=8, wrap=1; then binary E, value 9.
SATURATE=1, counting up to binary F, keep stepping -> binary stays F, value stays 8, each step gives tick=1 and wrap=1; switch dir=0 -> next step binary=E, wrap=0.
Drop en for 5 cycles after 1 prescaler clock, then raise it -> next tick arrives exactly 2 enabled cycles later; no tick while en=0.
Assert clr in the same cycle as step at binary=7 -> next cycle binary=0, value=0, tick=0; with GRAY_CNT_LOAD_EN, load with load_gray=C -> binary=8, then next step binary=9, value=D.
Assert rst asynchronously between clock edges at binary=A -> outputs 0 immediately without a clock edge; after release, the first tick occurs 3 enabled cycles later.
